// File: rtl/fnd_scan_controller_pkg.sv
// rtl/fnd_scan_controller_pkg.sv - segment constants, BCD->segment decode and sizing helpers
package fnd_scan_controller_pkg;

    // Active-low segments {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Decimal digit count of 2**w-1, i.e. BCD nibbles needed for a w-bit value
    function automatic int bcd_nibbles(input int w);
        longint unsigned v;
        int n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                n = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fnd_scan_controller_bin2bcd_seq.sv
// rtl/fnd_scan_controller_bin2bcd_seq.sv - sequential shift-add-3 binary to BCD converter
module bin2bcd_seq
    import fnd_scan_controller_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int NIB    = bcd_nibbles(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              commit,
    output logic              done,
    output logic [NIB*4-1:0]  bcd_out
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    conv_state_t       state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [DATA_W-1:0] bin_sr, bin_nxt;
    logic [NIB*4-1:0]  work, work_nxt, adj;
    logic [NIB*4-1:0]  out_nxt;
    logic              done_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bin_sr  <= '0;
            work    <= '0;
            bcd_out <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bin_sr  <= bin_nxt;
            work    <= work_nxt;
            bcd_out <= out_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        adj = work;
        for (int k = 0; k < NIB; k++) begin
            if (work[k*4 +: 4] >= 4'd5)
                adj[k*4 +: 4] = work[k*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bin_nxt   = bin_sr;
        work_nxt  = work;
        out_nxt   = bcd_out;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    bin_nxt   = din;
                    work_nxt  = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {work_nxt, bin_nxt} = {adj, bin_sr} << 1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == CW'(DATA_W - 1))
                    state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                // Result is published only here, so a partial conversion never escapes
                out_nxt  = work;
                done_nxt = 1'b1;
                if (start) begin
                    bin_nxt   = din;
                    work_nxt  = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy   = (state != ST_IDLE);
    assign commit = (state == ST_COMMIT);

endmodule

// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - multiplexed 7-segment scan controller with sequential BCD conversion
module fnd_scan_controller
    import fnd_scan_controller_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int SCAN_HZ     = 1_000,
    parameter int DATA_W      = 14,
    parameter int DIGITS      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic [DIGITS-1:0] dp_mask,
    input  logic              blank_en,
    output logic [DIGITS-1:0] fnd_digit,
    output logic [7:0]        fnd_data,
    output logic              busy,
    output logic              overflow
);

    localparam int TICK_DIV = CLK_FREQ_HZ / SCAN_HZ;
    localparam int TICK_W   = $clog2(TICK_DIV);
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NIB      = bcd_nibbles(DATA_W);
    localparam int EXT      = (DIGITS > NIB) ? DIGITS : NIB;
    localparam int EXT_W    = EXT * 4;

    logic [TICK_W-1:0]   tick;
    logic [IDX_W-1:0]    idx;
    logic [DIGITS*4-1:0] disp;
    logic                ovf;
    logic                pend_valid;
    logic [DATA_W-1:0]   pend_data;

    logic                conv_start, conv_busy, conv_commit, conv_done;
    logic                start_from_pend, start_from_in;
    logic [DATA_W-1:0]   conv_din;
    logic [NIB*4-1:0]    conv_bcd;
    logic [EXT_W-1:0]    bcd_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick <= '0;
            idx  <= '0;
        end else if (tick == TICK_W'(TICK_DIV - 1)) begin
            tick <= '0;
            idx  <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // Pending is drained when the converter is idle or finishing; a strobe on the
    // commit cycle is parked and starts one cycle later.
    assign start_from_pend = pend_valid && (!conv_busy || conv_commit);
    assign start_from_in   = in_valid && !conv_busy && !pend_valid;
    assign conv_start      = start_from_pend || start_from_in;
    assign conv_din        = start_from_pend ? pend_data : in_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else if (in_valid && !start_from_in) begin
            pend_valid <= 1'b1;
            pend_data  <= in_data;
        end else if (start_from_pend) begin
            pend_valid <= 1'b0;
        end
    end

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .NIB    (NIB)
    ) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start   (conv_start),
        .din     (conv_din),
        .busy    (conv_busy),
        .commit  (conv_commit),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    assign bcd_ext = EXT_W'(conv_bcd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp <= '0;
            ovf  <= 1'b0;
        end else if (conv_done) begin
            disp <= bcd_ext[DIGITS*4-1:0];
            ovf  <= |(bcd_ext >> (DIGITS * 4));
        end
    end

    assign busy      = conv_busy || pend_valid;
    assign overflow  = ovf;
    assign fnd_digit = ~(DIGITS'(1) << idx);

    always_comb begin
        logic       upper_nz;
        logic [7:0] seg;
        upper_nz = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(idx) && disp[j*4 +: 4] != 4'd0)
                upper_nz = 1'b1;
        end
        if (ovf)
            seg = SEG_DASH;
        else if (blank_en && idx != '0 && !upper_nz)
            seg = SEG_BLANK;
        else
            seg = seg_decode(disp[idx*4 +: 4]);
        if (dp_mask[idx])
            seg[7] = 1'b0;
        fnd_data = seg;
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb/tb_fnd_scan_controller.sv - directed self-checking bench for fnd_scan_controller
`timescale 1ns/1ps
module tb_fnd_scan_controller;

    logic        clk;
    logic        reset;
    logic [13:0] in_data;
    logic        in_valid;
    logic [3:0]  dp_mask;
    logic        blank_en;
    logic [3:0]  fnd_digit;
    logic [7:0]  fnd_data;
    logic        busy;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    fnd_scan_controller #(
        .CLK_FREQ_HZ (1000),
        .SCAN_HZ     (100),
        .DATA_W      (14),
        .DIGITS      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .dp_mask   (dp_mask),
        .blank_en  (blank_en),
        .fnd_digit (fnd_digit),
        .fnd_data  (fnd_data),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [13:0] v);
        in_data  = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic read_digit(input int i, output logic [7:0] seg);
        logic [3:0] want;
        int n;
        want = ~(4'b0001 << i);
        n = 0;
        while (fnd_digit !== want && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("scan_reach", {28'd0, fnd_digit}, {28'd0, want});
        seg = fnd_data;
    endtask

    logic [7:0] seg;
    logic [7:0] t11 [4];
    logic [7:0] t33 [4];
    logic [7:0] t1234 [4];
    int cur;

    initial begin
        t11   = '{8'hF9, 8'hF9, 8'hC0, 8'hC0};
        t33   = '{8'hB0, 8'hB0, 8'hC0, 8'hC0};
        t1234 = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

        reset = 1'b0; in_data = '0; in_valid = 1'b0; dp_mask = 4'b0000; blank_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_digit", fnd_digit, 4'b1110);
        chk("rst_data", fnd_data, 8'hC0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", overflow, 1'b0);

        // Scan advance every 10 clocks
        reset = 1'b1;
        repeat (9) @(negedge clk);
        chk("scan_hold", fnd_digit, 4'b1110);
        @(negedge clk);
        chk("scan_adv", fnd_digit, 4'b1101);

        // 1234: busy window and digits
        send(14'd1234);
        chk("busy_e0", busy, 1'b1);
        repeat (14) @(negedge clk);
        chk("busy_e14", busy, 1'b1);
        @(negedge clk);
        chk("busy_e15", busy, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            read_digit(i, seg);
            chk($sformatf("d1234_%0d", i), seg, t1234[i]);
        end

        // Leading-zero blanking on 7
        blank_en = 1'b1;
        send(14'd7);
        repeat (16) @(negedge clk);
        read_digit(0, seg); chk("blank_d0", seg, 8'hF8);
        for (int i = 1; i < 4; i++) begin
            read_digit(i, seg);
            chk($sformatf("blank_d%0d", i), seg, 8'hFF);
        end
        blank_en = 1'b0;
        for (int i = 1; i < 4; i++) begin
            read_digit(i, seg);
            chk($sformatf("noblank_d%0d", i), seg, 8'hC0);
        end

        // Overflow 12000, then 9999
        send(14'd12000);
        repeat (15) @(negedge clk);
        chk("ovf_e15", overflow, 1'b0);
        @(negedge clk);
        chk("ovf_e16", overflow, 1'b1);
        read_digit(0, seg); chk("ovf_d0", seg, 8'hBF);
        read_digit(3, seg); chk("ovf_d3", seg, 8'hBF);
        dp_mask = 4'b0100;
        read_digit(2, seg); chk("ovf_dp_d2", seg, 8'h3F);
        dp_mask = 4'b0000;
        send(14'd9999);
        repeat (16) @(negedge clk);
        chk("ovf_clear", overflow, 1'b0);
        read_digit(1, seg); chk("d9999_1", seg, 8'h90);
        read_digit(3, seg); chk("d9999_3", seg, 8'h90);

        // Pending last-wins: 11, then 22 and 33 during SHIFT
        send(14'd11);
        repeat (2) @(negedge clk);
        send(14'd22);
        repeat (2) @(negedge clk);
        send(14'd33);
        for (int k = 7; k <= 31; k++) begin
            @(negedge clk);
            cur = 0;
            for (int i = 0; i < 4; i++) if (fnd_digit == ~(4'b0001 << i)) cur = i;
            if (k <= 29) chk($sformatf("pend_busy_%0d", k), busy, 1'b1);
            if (k == 30) chk("pend_busy_end", busy, 1'b0);
            if (k >= 16 && k <= 30) chk($sformatf("show11_%0d", k), fnd_data, t11[cur]);
            if (k == 31) chk("show33", fnd_data, t33[cur]);
        end

        // Reset mid-conversion with a pending value
        send(14'd12000);
        repeat (16) @(negedge clk);
        chk("pre_rst_ovf", overflow, 1'b1);
        send(14'd5);
        repeat (3) @(negedge clk);
        send(14'd77);
        reset = 1'b0;
        #1;
        chk("mid_rst_digit", fnd_digit, 4'b1110);
        chk("mid_rst_data", fnd_data, 8'hC0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ovf", overflow, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_ovf", overflow, 1'b0);
        dp_mask = 4'b0100;
        read_digit(2, seg); chk("dp_d2", seg, 8'h40);
        read_digit(1, seg); chk("dp_d1", seg, 8'hC0);
        dp_mask = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
